dac_spi_driver: RTL

Downstream stage of top_vector_display. Takes the x_ch/y_ch beam coordinates and serialises them to an external dual-channel 12-bit SPI DAC of the MCP48x2 class: channel A = X, channel B = Y. After both channels are written, the block pulses LDAC so both analog outputs update together and the beam does not skew. It refreshes continuously while enabled.

---
 rtl/dac_spi_driver.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dac_spi_driver.sv
// Serialises X/Y beam coordinates to a dual-channel 12-bit SPI DAC (A = X, B = Y), then pulses LDAC.
// Optional macro DAC_SKIP_UNCHANGED_EN suppresses transactions when the coordinate pair is unchanged.
module dac_spi_driver #(
  parameter int OUT_WIDTH   = 8,
  parameter int CLK_DIV     = 2,
  parameter int CS_GAP      = 2,
  parameter int LDAC_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [OUT_WIDTH-1:0] x_in,
  input  logic [OUT_WIDTH-1:0] y_in,
  output logic                 cs_n,
  output logic                 sck,
  output logic                 sdi,
  output logic                 ldac_n,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SHIFT_A = 3'd1;
  localparam logic [2:0] S_GAP_A   = 3'd2;
  localparam logic [2:0] S_SHIFT_B = 3'd3;
  localparam logic [2:0] S_GAP_B   = 3'd4;
  localparam logic [2:0] S_LDAC    = 3'd5;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);
  localparam logic [15:0] LDAC_LAST = 16'(LDAC_CYCLES - 1);

  // Command word: channel, don't-care, GA=1 (1x), SHDN_n=1, then left-justified data.
  function automatic logic [15:0] f_frame(input logic ch, input logic [OUT_WIDTH-1:0] data);
    logic [11:0] d;
    d = 12'(data) << (12 - OUT_WIDTH);
    return {ch, 1'b0, 1'b1, 1'b1, d};
  endfunction

  logic [2:0]           r_state;
  logic [15:0]          r_cnt;
  logic [3:0]           r_bit;
  logic                 r_cs_n;
  logic                 r_sck;
  logic                 r_sdi;
  logic                 r_ldac_n;
  logic                 r_busy;
  logic                 r_frame_done;
  logic [15:0]          r_sr;
  logic [OUT_WIDTH-1:0] r_y_sh;

  logic        w_skip;
  logic        w_start;
  logic        w_shifting;
  logic        w_div_end;
  logic        w_fall;
  logic        w_load_b;
  logic [15:0] w_frame_a;
  logic [15:0] w_frame_b;

`ifdef DAC_SKIP_UNCHANGED_EN
  logic                 r_last_vld;
  logic [OUT_WIDTH-1:0] r_last_x;
  logic [OUT_WIDTH-1:0] r_last_y;

  assign w_skip = r_last_vld && (x_in == r_last_x) && (y_in == r_last_y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_vld <= 1'b0;
    end else if (w_start) begin
      r_last_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_last_x <= x_in;
      r_last_y <= y_in;
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  assign w_start    = (r_state == S_IDLE) && enable && !w_skip;
  assign w_shifting = (r_state == S_SHIFT_A) || (r_state == S_SHIFT_B);
  assign w_div_end  = (r_cnt == DIV_LAST);
  assign w_fall     = w_shifting && w_div_end && r_sck;
  assign w_load_b   = (r_state == S_GAP_A) && (r_cnt == GAP_LAST);
  assign w_frame_a  = f_frame(1'b0, x_in);
  assign w_frame_b  = f_frame(1'b1, r_y_sh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_cs_n       <= 1'b1;
      r_sck        <= 1'b0;
      r_sdi        <= 1'b0;
      r_ldac_n     <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_SHIFT_A;
            r_cs_n  <= 1'b0;
            r_sck   <= 1'b0;
            r_sdi   <= w_frame_a[15];
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
          end
        end
        S_SHIFT_A, S_SHIFT_B: begin
          if (w_div_end) begin
            r_cnt <= '0;
            if (r_sck) begin
              r_sck <= 1'b0;
              // End of the 16th high phase releases cs_n together with sck.
              if (r_bit == 4'd15) begin
                r_cs_n  <= 1'b1;
                r_state <= (r_state == S_SHIFT_A) ? S_GAP_A : S_GAP_B;
              end else begin
                r_bit <= r_bit + 4'd1;
                r_sdi <= r_sr[14];
              end
            end else begin
              r_sck <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_GAP_A: begin
          if (w_load_b) begin
            r_state <= S_SHIFT_B;
            r_cs_n  <= 1'b0;
            r_sdi   <= w_frame_b[15];
            r_cnt   <= '0;
            r_bit   <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_GAP_B: begin
          if (r_cnt == GAP_LAST) begin
            r_state      <= S_LDAC;
            r_ldac_n     <= 1'b0;
            r_cnt        <= '0;
            r_frame_done <= (LDAC_CYCLES == 1);
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_LDAC: begin
          if (r_cnt == LDAC_LAST) begin
            r_state      <= S_IDLE;
            r_ldac_n     <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
          end else begin
            r_cnt        <= r_cnt + 16'd1;
            r_frame_done <= (r_cnt + 16'd1 == LDAC_LAST);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Shift data path; sdi is taken from bit 14 before each shift so it leads the register by one.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_y_sh <= y_in;
      r_sr   <= w_frame_a;
    end else if (w_load_b) begin
      r_sr <= w_frame_b;
    end else if (w_fall && (r_bit != 4'd15)) begin
      r_sr <= {r_sr[14:0], 1'b0};
    end
  end

  assign cs_n       = r_cs_n;
  assign sck        = r_sck;
  assign sdi        = r_sdi;
  assign ldac_n     = r_ldac_n;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule
